// File: rtl/hdmi_rx_pkg.sv
// Shared TMDS lane constants: the four DVI/HDMI control-period tokens and the
// word-aligner state encoding (SEARCH=0, LOCKED=1, SLIP=2).
package hdmi_rx_pkg;

  localparam logic [9:0] CTRL_TOK_0 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOK_1 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOK_2 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOK_3 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_LOCKED = 2'd1,
    ST_SLIP   = 2'd2
  } align_state_e;

endpackage

// File: rtl/tmds_ctrl_token_det.sv
// Combinational detector: flags a 10-bit TMDS word that equals one of the
// four control-period tokens.
module tmds_ctrl_token_det
  import hdmi_rx_pkg::*;
(
  input  logic [9:0] i_word,
  output logic       o_is_token
);

  assign o_is_token = (i_word == CTRL_TOK_0) || (i_word == CTRL_TOK_1) ||
                      (i_word == CTRL_TOK_2) || (i_word == CTRL_TOK_3);

endmodule

// File: rtl/hdmi_rx_word_align.sv
// TMDS lane word aligner: hunts bit offsets 0..9 for a run of control tokens,
// holds lock while tokens keep appearing. Define HDMI_RX_ALIGN_DBG_EN for debug ports.
module hdmi_rx_word_align
  import hdmi_rx_pkg::*;
#(
  parameter int TOKEN_RUN  = 8,
  parameter int SEARCH_WIN = 1024,
  parameter int LOSS_WIN   = 2**21
) (
  input  logic       I_parallel_clk,
  input  logic       I_rst,
  input  logic [9:0] I_raw_data,
  output logic [9:0] O_aligned_data,
  output logic       O_locked,
  output logic       O_slip
`ifdef HDMI_RX_ALIGN_DBG_EN
  ,
  output logic [3:0] O_dbg_offset,
  output logic [1:0] O_dbg_state
`endif
);

  // run_cnt must be able to hold TOKEN_RUN itself, hence the +1
  localparam int RUN_W  = $clog2(TOKEN_RUN + 1);
  localparam int WIN_W  = $clog2(SEARCH_WIN);
  localparam int LOSS_W = $clog2(LOSS_WIN);

  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(TOKEN_RUN);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WIN - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WIN - 1);

  align_state_e      r_state, w_state_nxt;
  logic [9:0]        r_raw_d1;
  logic [3:0]        r_offset, w_offset_nxt;
  logic [RUN_W-1:0]  r_run_cnt, w_run_nxt;
  logic [WIN_W-1:0]  r_win_cnt, w_win_nxt;
  logic [LOSS_W-1:0] r_loss_cnt, w_loss_nxt;
  logic [9:0]        r_aligned;
  logic              r_locked;
  logic              r_slip;

  logic [19:0] w_cat;
  logic [19:0] w_shift;
  logic [9:0]  w_win;
  logic        w_is_token;

  // bit 0 is earliest, so the older word sits in the low half
  assign w_cat   = {I_raw_data, r_raw_d1};
  assign w_shift = w_cat >> r_offset;
  assign w_win   = w_shift[9:0];

  tmds_ctrl_token_det u_tok_det (
    .i_word     (w_win),
    .o_is_token (w_is_token)
  );

  always_ff @(posedge I_parallel_clk or posedge I_rst) begin
    if (I_rst) r_state <= ST_SEARCH;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_offset_nxt = r_offset;
    w_run_nxt    = r_run_cnt;
    w_win_nxt    = r_win_cnt;
    w_loss_nxt   = '0;
    case (r_state)
      ST_SEARCH: begin
        // lock takes priority over window expiry
        if (r_run_cnt == RUN_MAX)       w_state_nxt = ST_LOCKED;
        else if (r_win_cnt == WIN_LAST) w_state_nxt = ST_SLIP;
        if (!w_is_token)                w_run_nxt = '0;
        else if (r_run_cnt != RUN_MAX)  w_run_nxt = r_run_cnt + 1'b1;
        if (r_win_cnt != WIN_LAST)      w_win_nxt = r_win_cnt + 1'b1;
      end
      ST_LOCKED: begin
        if (r_loss_cnt == LOSS_LAST) w_state_nxt = ST_SLIP;
        if (w_is_token)                  w_loss_nxt = '0;
        else if (r_loss_cnt != LOSS_LAST) w_loss_nxt = r_loss_cnt + 1'b1;
        else                             w_loss_nxt = r_loss_cnt;
      end
      ST_SLIP: begin
        w_state_nxt  = ST_SEARCH;
        w_offset_nxt = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
        w_run_nxt    = '0;
        w_win_nxt    = '0;
      end
      default: w_state_nxt = ST_SEARCH;
    endcase
  end

  always_ff @(posedge I_parallel_clk or posedge I_rst) begin
    if (I_rst) begin
      r_raw_d1   <= '0;
      r_offset   <= '0;
      r_run_cnt  <= '0;
      r_win_cnt  <= '0;
      r_loss_cnt <= '0;
      r_aligned  <= '0;
      r_locked   <= 1'b0;
      r_slip     <= 1'b0;
    end else begin
      r_raw_d1   <= I_raw_data;
      r_offset   <= w_offset_nxt;
      r_run_cnt  <= w_run_nxt;
      r_win_cnt  <= w_win_nxt;
      r_loss_cnt <= w_loss_nxt;
      r_aligned  <= w_win;
      // rises one cycle after entering LOCKED, drops as SLIP is entered
      r_locked   <= (r_state == ST_LOCKED) && (w_state_nxt == ST_LOCKED);
      r_slip     <= (w_state_nxt == ST_SLIP);
    end
  end

  assign O_aligned_data = r_aligned;
  assign O_locked       = r_locked;
  assign O_slip         = r_slip;

`ifdef HDMI_RX_ALIGN_DBG_EN
  assign O_dbg_offset = r_offset;
  assign O_dbg_state  = r_state;
`endif

endmodule

// File: tb/tb_hdmi_rx_word_align.sv
// Self-checking bench for hdmi_rx_word_align (TOKEN_RUN=8, SEARCH_WIN=32,
// LOSS_WIN=64); debug ports are checked when HDMI_RX_ALIGN_DBG_EN is defined.
`timescale 1ns/1ps
module tb_hdmi_rx_word_align;

  localparam int TOKEN_RUN  = 8;
  localparam int SEARCH_WIN = 32;
  localparam int LOSS_WIN   = 64;
  localparam logic [9:0] T0   = 10'b1101010100;
  localparam logic [9:0] ONES = 10'h3FF;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] raw;
  logic [9:0] aligned;
  logic       locked;
  logic       slip;
`ifdef HDMI_RX_ALIGN_DBG_EN
  logic [3:0] dbg_off;
  logic [1:0] dbg_st;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  hdmi_rx_word_align #(
    .TOKEN_RUN  (TOKEN_RUN),
    .SEARCH_WIN (SEARCH_WIN),
    .LOSS_WIN   (LOSS_WIN)
  ) dut (
    .I_parallel_clk (clk),
    .I_rst          (rst),
    .I_raw_data     (raw),
    .O_aligned_data (aligned),
    .O_locked       (locked),
    .O_slip         (slip)
`ifdef HDMI_RX_ALIGN_DBG_EN
    ,
    .O_dbg_offset   (dbg_off),
    .O_dbg_state    (dbg_st)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] exp_q[$];
  logic [9:0] prev_in;
  int         m_off;

  typedef struct {
    logic [9:0] din;
    logic       exp_locked;
    logic       exp_slip;
  } vec_t;
  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one word; when sb is set the expected aligned word for the
  // bench-known offset is queued and compared after the edge.
  task automatic step(input logic [9:0] d, input bit sb);
    logic [19:0] cat;
    if (sb) begin
      cat = {d, prev_in} >> m_off;
      exp_q.push_back(cat[9:0]);
    end
    raw     = d;
    prev_in = d;
    @(posedge clk);
    #1;
    if (sb && exp_q.size() > 0) check("sb_aligned", aligned, exp_q.pop_front());
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    raw     = '0;
    prev_in = '0;
    m_off   = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_aligned", aligned, 10'd0);
    check("rst_locked", locked, 1'b0);
    check("rst_slip", slip, 1'b0);
`ifdef HDMI_RX_ALIGN_DBG_EN
    check("rst_dbg_off", dbg_off, 4'd0);
    check("rst_dbg_st", dbg_st, 2'd0);
`endif
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus / scoreboard ----------------
  initial begin
    int fall_k, lock_k, n_slip, locked_seen;
    int slip_steps[$];
    logic [19:0] tt;
    logic [9:0]  w3;

    // aligned tokens: locked visible 2+8+1 cycles after the first token
    for (int i = 0; i < 16; i++) begin
      tbl[i].din        = (i < 12) ? T0 : ONES;
      tbl[i].exp_locked = (i >= 10);
      tbl[i].exp_slip   = 1'b0;
    end

    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].din, 1'b1);
      check($sformatf("tbl_locked_%0d", i), locked, tbl[i].exp_locked);
      check($sformatf("tbl_slip_%0d", i), slip, tbl[i].exp_slip);
    end

    // loss of lock: the 64th token-free window's edge drops lock
    fall_k = -1;
    n_slip = 0;
    for (int k = 16; k <= 77; k++) begin
      step(ONES, 1'b1);
      if (!locked && fall_k < 0) fall_k = k;
      if (slip) n_slip++;
    end
    check("loss_fall_cycle", fall_k, 76);
    check("loss_slip_count", n_slip, 1);
    m_off = 1;
    for (int k = 0; k < 8; k++) step(10'($urandom_range(0, 1023)), 1'b1);
`ifdef HDMI_RX_ALIGN_DBG_EN
    check("loss_dbg_off", dbg_off, 4'd1);
`endif

    // no tokens: ten slips at 31+33n, offset wraps 9 -> 0
    do_reset();
    slip_steps.delete();
    for (int k = 0; k <= 329; k++) begin
      step(ONES, 1'b0);
      if (slip) slip_steps.push_back(k);
    end
    check("wrap_slip_count", slip_steps.size(), 10);
    for (int n = 0; n < slip_steps.size(); n++)
      check($sformatf("wrap_slip_at_%0d", n), slip_steps[n], 31 + 33 * n);
    m_off = 0;
    for (int k = 0; k < 6; k++) step(10'($urandom_range(0, 1023)), 1'b1);
`ifdef HDMI_RX_ALIGN_DBG_EN
    check("wrap_dbg_off", dbg_off, 4'd0);
`endif

    // runs of 7 tokens broken by a non-token never lock
    do_reset();
    slip_steps.delete();
    locked_seen = 0;
    for (int k = 0; k < 110; k++) begin
      step((k % 8 == 7) ? ONES : T0, 1'b0);
      if (locked) locked_seen++;
      if (slip) slip_steps.push_back(k);
    end
    check("run7_never_locked", locked_seen, 0);
    check("run7_slip_count", slip_steps.size(), 3);
    for (int n = 0; n < slip_steps.size(); n++)
      check($sformatf("run7_slip_at_%0d", n), slip_steps[n], 31 + 33 * n);

    // stream shifted by 3 bits: three slips, then lock at offset 3
    do_reset();
    tt = {T0, T0};
    w3 = tt[16:7];
    n_slip = 0;
    lock_k = -1;
    for (int k = 0; k < 115; k++) begin
      step(w3, 1'b0);
      if (slip) n_slip++;
      if (locked && lock_k < 0) lock_k = k;
    end
    check("shift3_slip_count", n_slip, 3);
    check("shift3_lock_cycle", lock_k, 108);
    for (int k = 0; k < 4; k++) begin
      step(w3, 1'b0);
      check($sformatf("shift3_aligned_%0d", k), aligned, T0);
    end
`ifdef HDMI_RX_ALIGN_DBG_EN
    check("shift3_dbg_off", dbg_off, 4'd3);
`endif

    // asynchronous reset while locked, then search restarts at offset 0
    #2;
    rst = 1'b1;
    #1;
    check("arst_locked", locked, 1'b0);
    check("arst_aligned", aligned, 10'd0);
    check("arst_slip", slip, 1'b0);
    @(posedge clk);
    #1;
    prev_in = '0;
    m_off   = 0;
    exp_q.delete();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) step(10'($urandom_range(0, 1023)), 1'b1);
`ifdef HDMI_RX_ALIGN_DBG_EN
    check("arst_dbg_off", dbg_off, 4'd0);
`endif

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hdmi_rx_word_align.md
HDMI_RX_WORD_ALIGN -- requirements
Module: hdmi_rx_word_align

Interface
REQ-001 SHALL have parameter TOKEN_RUN, default 8: number of consecutive TMDS control tokens that declares lock.
REQ-002 SHALL have parameter SEARCH_WIN, default 1024: number of cycles spent testing one bit offset before slipping.
REQ-003 SHALL have parameter LOSS_WIN, default 2^21: number of cycles in LOCKED with no control token before lock is dropped.
REQ-004 SHALL have one clock and one reset, as listed below; I_rst is asynchronous and active-high.
REQ-005 I_parallel_clk  in  1  pixel-rate clock; all logic runs in this domain.
REQ-006 I_rst  in  1  asynchronous active-high reset.
REQ-007 I_raw_data  in  10  unaligned deserialised lane word from the lane deserialiser; bit 0 is the earliest received bit.
REQ-008 O_aligned_data  out  10  word-aligned TMDS symbol.
REQ-009 O_locked  out  1  high while the block is in state LOCKED.
REQ-010 O_slip  out  1  one-cycle pulse on each change of bit offset.

Function
REQ-011 Each cycle SHALL register raw_d1 <= I_raw_data.
REQ-012 SHALL form cat[19:0] = {I_raw_data, raw_d1} and select win = cat[offset+9:offset], where offset is 0..9.
REQ-013 O_aligned_data SHALL be win, registered; latency from I_raw_data to O_aligned_data is exactly 2 cycles.
REQ-014 win is a control token iff it equals 10'b1101010100, 10'b0010101011, 10'b0101010100 or 10'b1010101011.
REQ-015 The FSM SHALL have states SEARCH, LOCKED and SLIP; the reset state is SEARCH.
REQ-016 SEARCH: run_cnt SHALL increment on a token and clear on a non-token; win_cnt SHALL increment every cycle.
REQ-017 SEARCH: when run_cnt reaches TOKEN_RUN, the FSM SHALL go to LOCKED and O_locked SHALL rise the next cycle.
REQ-018 SEARCH: when win_cnt reaches SEARCH_WIN-1 without lock, the FSM SHALL go to SLIP.
REQ-019 If the lock and window-expiry conditions occur in the same cycle, lock SHALL win.
REQ-020 SLIP (exactly 1 cycle): offset SHALL become offset==9 ? 0 : offset+1, O_slip SHALL pulse, run_cnt and win_cnt SHALL clear, and the FSM SHALL return to SEARCH.
REQ-021 LOCKED: loss_cnt SHALL clear on any token and increment otherwise.
REQ-022 LOCKED: when loss_cnt reaches LOSS_WIN-1, the FSM SHALL go to SLIP and O_locked SHALL fall the same cycle.
REQ-023 Offset SHALL never change while in LOCKED.
REQ-024 All counters SHALL saturate, never wrap, and be sized by $clog2 of their parameter.
REQ-025 O_aligned_data SHALL pass data in every state; downstream qualifies it with O_locked.

Reset
REQ-026 While I_rst is high: state=SEARCH, offset=0, all counters=0, raw_d1=0, O_aligned_data=0, O_locked=0, O_slip=0.
REQ-027 Reset asserted mid-operation SHALL abort lock immediately, asynchronously.
REQ-028 After release, the search SHALL restart at offset 0.

Configuration
REQ-029 Macro HDMI_RX_ALIGN_DBG_EN, when defined, SHALL add output O_dbg_offset[3:0] (current offset) and output O_dbg_state[1:0] (SEARCH=0, LOCKED=1, SLIP=2).
REQ-030 Without HDMI_RX_ALIGN_DBG_EN, these ports and their logic SHALL be absent; all other behaviour is identical either way.

Structure
REQ-031 The four control-token constants and the state encoding SHALL live in the shared package hdmi_rx_pkg.
REQ-032 The token compare SHALL be a sub-module, tmds_ctrl_token_det: 10-bit combinational input, 1-bit is-token output.
REQ-033 One instance of this block is used per lane, placed after each lane deserialiser in the HDMI RX path.

Verification
REQ-034 Aligned stream with 12 consecutive tokens at true offset 0 -> O_locked high 2+8+1 cycles after the first token; O_slip never pulses.
REQ-035 Stream shifted by 3 bits with continuous tokens -> exactly 3 O_slip pulses, then lock with offset=3; O_aligned_data equals 10'b1101010100 when fed.
REQ-036 With TOKEN_RUN=8 and LOSS_WIN=64: lock, then 64 cycles of 10'h3FF -> O_locked falls, O_slip pulses, offset advances by 1.
REQ-037 Offset 9 with no tokens for SEARCH_WIN cycles -> offset wraps to 0.
REQ-038 Runs of 7 tokens separated by one non-token, repeated -> never locks; slips every SEARCH_WIN+1 cycles.
REQ-039 I_rst pulsed while LOCKED -> O_locked=0 and O_aligned_data=0 immediately; offset=0 after release.
